// File: rtl/dff_chain_loader.sv
// Serial load/readback controller for a q->d chain of single-bit reset flops.
// Shifts a parallel word in MSB-first while capturing the old chain contents.
module dff_chain_loader #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned CLR_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             clr_first,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out,
    output logic             chain_d,
    output logic             chain_en,
    output logic             chain_reset,
    input  logic             chain_q
);

    localparam int unsigned MaxCount = (WIDTH > CLR_CYCLES) ? WIDTH : CLR_CYCLES;
    localparam int unsigned CntW     = (MaxCount > 1) ? $clog2(MaxCount) : 1;
    localparam logic [CntW-1:0] CntShift = CntW'(WIDTH - 1);
    localparam logic [CntW-1:0] CntClear = CntW'(CLR_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StShift,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  sh_q, sh_d;
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic              clr_q, clr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sh_q    <= '0;
            dout_q  <= '0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            dout_q  <= dout_d;
            clr_q   <= clr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        dout_d  = dout_q;
        clr_d   = clr_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sh_d  = data_in;
                    clr_d = clr_first;
                    if (clr_first) begin
                        state_d = StClear;
                        cnt_d   = CntClear;
                    end else begin
                        state_d = StShift;
                        cnt_d   = CntShift;
                    end
                end
            end
            StClear: begin
                if (cnt_q == '0) begin
                    state_d = StShift;
                    cnt_d   = CntShift;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StShift: begin
                // chain_q is the chain end before this edge's shift lands
                sh_d   = {sh_q[WIDTH-2:0], 1'b0};
                dout_d = {dout_q[WIDTH-2:0], chain_q};
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign data_out    = dout_q;
    assign chain_en    = (state_q == StShift);
    assign chain_d     = (state_q == StShift) ? sh_q[WIDTH-1] : 1'b0;
    // Combinational so block reset also clears the chain in the same cycle
    assign chain_reset = reset | (state_q == StClear);

    // A cleared chain must read back as zeros while the new word shifts in
    a_cleared_readback : assert property (@(posedge clk) disable iff (reset)
        (state_q == StShift && clr_q) |-> !chain_q);

endmodule

// File: tb/tb_dff_chain_loader.sv
// Scoreboard bench for dff_chain_loader: two instances (8/2 and 2/1), each
// driving a behavioural model of the dff1 chain.
module tb_dff_chain_loader;

    localparam int W  = 8;
    localparam int C  = 2;
    localparam int W2 = 2;
    localparam int C2 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start, clr_first;
    logic [W-1:0]  data_in, data_out;
    logic          busy, done, chain_d, chain_en, chain_reset, chain_q;
    logic [W-1:0]  chain;

    logic          reset2, start2, clr2;
    logic [W2-1:0] din2, dout2;
    logic          busy2, done2, chain2_d, chain2_en, chain2_reset, chain2_q;
    logic [W2-1:0] chain2;

    dff_chain_loader #(.WIDTH(W), .CLR_CYCLES(C)) dut (
        .clk(clk), .reset(reset), .start(start), .clr_first(clr_first),
        .data_in(data_in), .busy(busy), .done(done), .data_out(data_out),
        .chain_d(chain_d), .chain_en(chain_en), .chain_reset(chain_reset),
        .chain_q(chain_q)
    );

    dff_chain_loader #(.WIDTH(W2), .CLR_CYCLES(C2)) dut2 (
        .clk(clk), .reset(reset2), .start(start2), .clr_first(clr2),
        .data_in(din2), .busy(busy2), .done(done2), .data_out(dout2),
        .chain_d(chain2_d), .chain_en(chain2_en), .chain_reset(chain2_reset),
        .chain_q(chain2_q)
    );

    // Behavioural flop chains: flop 0 takes chain_d, the last flop feeds chain_q
    always @(posedge clk) begin
        if (chain_reset) chain <= '0;
        else if (chain_en) chain <= {chain[W-2:0], chain_d};
        if (chain2_reset) chain2 <= '0;
        else if (chain2_en) chain2 <= {chain2[W2-2:0], chain2_d};
    end
    assign chain_q  = chain[W-1];
    assign chain2_q = chain2[W2-1];

    typedef struct {
        logic [7:0] out;
        logic [7:0] img;
        logic       clr;
        int         t;
    } sb_t;

    sb_t        q1[$];
    sb_t        q2[$];
    logic [7:0] exp1 = '0;
    logic [1:0] exp2 = '0;
    int         cyc = 0;
    int         n_total = 0;
    int         n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Latency counts cycles up to and including the done cycle, where the
    // accept edge closes cycle 0.
    int en1 = 0, rc1 = 0, en2 = 0, rc2 = 0;
    always @(negedge clk) begin
        sb_t e;
        if (reset) begin
            en1 = 0;
            rc1 = 0;
        end else begin
            if (chain_en) en1++;
            if (chain_reset) rc1++;
            if (done) begin
                if (q1.size() == 0) begin
                    chk("spurious_done", done, 1'b0);
                end else begin
                    e = q1.pop_front();
                    chk("data_out", data_out, e.out);
                    chk("chain", chain, e.img);
                    chk("latency", cyc - e.t + 1, e.clr ? W + C + 1 : W + 1);
                    chk("en_cycles", en1, W);
                    chk("clr_cycles", rc1, e.clr ? C : 0);
                end
                en1 = 0;
                rc1 = 0;
            end
        end
    end

    always @(negedge clk) begin
        sb_t e;
        if (reset2) begin
            en2 = 0;
            rc2 = 0;
        end else begin
            if (chain2_en) en2++;
            if (chain2_reset) rc2++;
            if (done2) begin
                if (q2.size() == 0) begin
                    chk("w2_spurious_done", done2, 1'b0);
                end else begin
                    e = q2.pop_front();
                    chk("w2_data_out", dout2, e.out);
                    chk("w2_chain", chain2, e.img);
                    chk("w2_latency", cyc - e.t + 1, e.clr ? W2 + C2 + 1 : W2 + 1);
                    chk("w2_en_cycles", en2, W2);
                    chk("w2_clr_cycles", rc2, e.clr ? C2 : 0);
                end
                en2 = 0;
                rc2 = 0;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int inst, input logic [7:0] d, input logic c);
        sb_t e;
        e.clr = c;
        e.t   = cyc;
        if (inst == 1) begin
            e.out = c ? 8'h00 : exp1;
            e.img = d;
            q1.push_back(e);
            exp1 = d;
        end else begin
            e.out = c ? 8'h00 : {6'b0, exp2};
            e.img = {6'b0, d[1:0]};
            q2.push_back(e);
            exp2 = d[1:0];
        end
    endtask

    task automatic wait_idle(input int inst);
        int n = 0;
        while (((inst == 1) ? busy : busy2) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("idle_timeout", (inst == 1) ? busy : busy2, 1'b0);
    endtask

    task automatic wait_done(input int inst);
        int n = 0;
        while (((inst == 1) ? q1.size() : q2.size()) != 0 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("done_timeout", (inst == 1) ? q1.size() : q2.size(), 0);
    endtask

    task automatic load(input int inst, input logic [7:0] d, input logic c);
        wait_idle(inst);
        if (inst == 1) begin
            start = 1'b1; data_in = d; clr_first = c;
        end else begin
            start2 = 1'b1; din2 = d[1:0]; clr2 = c;
        end
        tick();
        push(inst, d, c);
        if (inst == 1) start = 1'b0;
        else start2 = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; clr_first = 1'b0; data_in = '0;
        reset2 = 1'b1; start2 = 1'b0; clr2 = 1'b0; din2 = '0;
        tick();
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_chain_en", chain_en, 1'b0);
        chk("rst_chain_d", chain_d, 1'b0);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_chain_reset", chain_reset, 1'b1);
        reset = 1'b0;
        reset2 = 1'b0;
        tick();

        // Preset A5, then load 3C without clear
        load(1, 8'hA5, 1'b0);
        wait_done(1);
        load(1, 8'h3C, 1'b0);
        wait_done(1);

        // Chain at FF, load 81 with clear
        load(1, 8'hFF, 1'b0);
        wait_done(1);
        load(1, 8'h81, 1'b1);
        wait_done(1);

        // Start pulse during SHIFT is ignored
        load(1, 8'h5A, 1'b0);
        repeat (3) tick();
        start = 1'b1;
        data_in = 8'h00;
        tick();
        start = 1'b0;
        wait_done(1);
        repeat (12) tick();
        chk("ignored_start_busy", busy, 1'b0);

        // Reset on the 4th SHIFT cycle aborts the load
        load(1, 8'hC3, 1'b0);
        repeat (3) tick();
        reset = 1'b1;
        @(negedge clk);
        chk("abort_chain_reset", chain_reset, 1'b1);
        tick();
        q1.delete();
        exp1 = 8'h00;
        chk("abort_busy", busy, 1'b0);
        chk("abort_chain_en", chain_en, 1'b0);
        chk("abort_data_out", data_out, 8'h00);
        chk("abort_done", done, 1'b0);
        chk("abort_chain", chain, 8'h00);
        // Reset and start together: start dropped
        start = 1'b1;
        data_in = 8'hFF;
        tick();
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("start_dropped", busy, 1'b0);
        tick();

        // Start held high: a new request every WIDTH+2 cycles
        wait_idle(1);
        start = 1'b1;
        clr_first = 1'b0;
        for (int k = 0; k < 6; k++) begin
            data_in = (k % 2 == 0) ? 8'h0F : 8'hF0;
            tick();
            push(1, data_in, 1'b0);
            if (k < 5) repeat (W + 1) tick();
        end
        start = 1'b0;
        wait_done(1);

        // WIDTH=2, CLR_CYCLES=1 with random words
        for (int k = 0; k < 8; k++) begin
            load(2, 8'($urandom_range(0, 3)), 1'(k % 2));
            wait_done(2);
        end
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad + 1);
        $fatal(1);
    end

endmodule
